// File: rtl/dmem_initiator.sv
// dmem_initiator: load/store access controller on the requesting side of a
// synchronous single-port data memory. It handles one access at a time and
// sequences the request, the memory issue, the read latency and the response.
// Out-of-range addresses are answered with an error and never reach memory.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   req_valid/req_ready      request handshake (req_we, req_addr, req_wdata)
//   rsp_valid/rsp_ready      response handshake (rsp_rdata, rsp_err)
//   mem_we/mem_a/mem_wd      memory write enable, address, write data
//   mem_rd                   memory read data (registered inside the memory)
//   busy                     high whenever the controller is not idle
//   access_cnt               completed response handshakes, wraps
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | memory samples mem_a/mem_wd/mem_we at the end of this cycle
// WAIT  | load latency countdown; mem_rd is valid when the counter is 0
// RESP  | response presented, held until rsp_ready
module dmem_initiator #(
  parameter int WORD_SIZE     = 32,
  parameter int DATA_MEM_SIZE = 128,
  parameter int MEM_LAT       = 1,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_a,
  output logic [WORD_SIZE-1:0] mem_wd,
  input  logic [WORD_SIZE-1:0] mem_rd,
  output logic                 busy,
  output logic [CNT_W-1:0]     access_cnt
);

  // MEM_LAT is at most 8, so the countdown start value fits in 3 bits.
  localparam int LAT_W = 3;
  localparam logic [WORD_SIZE-1:0] ADDR_LIMIT = WORD_SIZE'(DATA_MEM_SIZE);
  localparam logic [LAT_W-1:0]     LAT_LOAD   = LAT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state, state_nxt;
  logic [LAT_W-1:0]     lat_cnt, lat_cnt_nxt;
  logic                 addr_ok;
  logic                 req_ready_nxt, rsp_valid_nxt, rsp_err_nxt, mem_we_nxt, busy_nxt;
  logic [WORD_SIZE-1:0] rsp_rdata_nxt, mem_a_nxt, mem_wd_nxt;
  logic [CNT_W-1:0]     access_cnt_nxt;

  assign addr_ok = (req_addr < ADDR_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      mem_we     <= 1'b0;
      mem_a      <= '0;
      mem_wd     <= '0;
      busy       <= 1'b0;
      access_cnt <= '0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_cnt_nxt;
      req_ready  <= req_ready_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_rdata  <= rsp_rdata_nxt;
      rsp_err    <= rsp_err_nxt;
      mem_we     <= mem_we_nxt;
      mem_a      <= mem_a_nxt;
      mem_wd     <= mem_wd_nxt;
      busy       <= busy_nxt;
      access_cnt <= access_cnt_nxt;
    end
  end

  // In ISSUE the registered mem_we still carries the accepted req_we.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = addr_ok ? ISSUE : RESP;
      ISSUE:   state_nxt = mem_we ? RESP : WAIT;
      WAIT:    if (lat_cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lat_cnt_nxt    = lat_cnt;
    rsp_rdata_nxt  = rsp_rdata;
    rsp_err_nxt    = rsp_err;
    mem_we_nxt     = mem_we;
    mem_a_nxt      = mem_a;
    mem_wd_nxt     = mem_wd;
    access_cnt_nxt = access_cnt;
    req_ready_nxt  = (state_nxt == IDLE);
    rsp_valid_nxt  = (state_nxt == RESP);
    busy_nxt       = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (addr_ok) begin
            mem_a_nxt  = req_addr;
            mem_wd_nxt = req_wdata;
            mem_we_nxt = req_we;
          end else begin
            rsp_err_nxt   = 1'b1;
            rsp_rdata_nxt = '0;
          end
        end
      end
      ISSUE: begin
        // Drop write enable at the sampling edge: one-cycle store pulse.
        mem_we_nxt = 1'b0;
        if (mem_we) begin
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b0;
        end else begin
          lat_cnt_nxt = LAT_LOAD;
        end
      end
      WAIT: begin
        if (lat_cnt != '0) begin
          lat_cnt_nxt = lat_cnt - 1'b1;
        end else begin
          rsp_rdata_nxt = mem_rd;
          rsp_err_nxt   = 1'b0;
        end
      end
      RESP: begin
        if (rsp_ready) access_cnt_nxt = access_cnt + 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_initiator.sv
module tb_dmem_initiator;
  localparam int W    = 32;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst[2];
  logic         req_valid[2], req_ready[2], req_we[2];
  logic         rsp_valid[2], rsp_ready[2], rsp_err[2], mem_we[2], busy[2];
  logic [W-1:0] req_addr[2], req_wdata[2], rsp_rdata[2], mem_a[2], mem_wd[2], mem_rd[2];
  logic [15:0]  cnt0;
  logic [3:0]   cnt1;

  logic [31:0]  mem [2][128] = '{default: '0};
  logic [31:0]  pipe[2][8]   = '{default: '0};
  logic [31:0]  ref_mem[2][128];
  int           exp_cnt[2];
  exp_t         sb[$];
  int           checks = 0;
  int           fails  = 0;

  dmem_initiator #(.WORD_SIZE(32), .DATA_MEM_SIZE(128), .MEM_LAT(LAT0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .mem_we(mem_we[0]), .mem_a(mem_a[0]), .mem_wd(mem_wd[0]), .mem_rd(mem_rd[0]),
    .busy(busy[0]), .access_cnt(cnt0)
  );

  dmem_initiator #(.WORD_SIZE(32), .DATA_MEM_SIZE(128), .MEM_LAT(LAT1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .mem_we(mem_we[1]), .mem_a(mem_a[1]), .mem_wd(mem_wd[1]), .mem_rd(mem_rd[1]),
    .busy(busy[1]), .access_cnt(cnt1)
  );

  // Synchronous RAM: address/we/wd sampled at the edge, read data delayed
  // through a pipeline whose tap sets the latency of each instance.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 7; k > 0; k--) pipe[i][k] <= pipe[i][k-1];
      pipe[i][0] <= mem[i][mem_a[i][6:0]];
      if (mem_we[i]) mem[i][mem_a[i][6:0]] <= mem_wd[i];
    end
  end
  assign mem_rd[0] = pipe[0][LAT0-1];
  assign mem_rd[1] = pipe[1][LAT1-1];

  function automatic logic [31:0] get_cnt(input int i);
    return (i == 0) ? {16'h0, cnt0} : {28'h0, cnt1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete access: drive the request, follow it to its response,
  // optionally hold off rsp_ready for 'hold' cycles, then handshake.
  task automatic access(input int i, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold);
    exp_t        e;
    int          lat, we_cycles, mask;
    bit          ok;
    logic [31:0] a_before;
    ok      = (addr < 32'd128);
    mask    = (i == 0) ? 32'hFFFF : 32'hF;
    e.err   = !ok;
    e.rdata = (ok && !we) ? ref_mem[i][addr[6:0]] : 32'h0;
    e.lat   = !ok ? 1 : (we ? 2 : ((i == 0) ? LAT0 : LAT1) + 2);
    if (ok && we) ref_mem[i][addr[6:0]] = wdata;
    sb.push_back(e);
    a_before = mem_a[i];
    chk("req_ready_idle", req_ready[i], 1);
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = addr; req_wdata[i] = wdata;
    rsp_ready[i] = (hold == 0);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    lat = 1; we_cycles = 0;
    while (!rsp_valid[i] && lat < 40) begin
      if (mem_we[i]) begin
        we_cycles++;
        chk("store_mem_a", mem_a[i], addr);
        chk("store_mem_wd", mem_wd[i], wdata);
      end
      @(posedge clk); #1;
      lat++;
    end
    if (mem_we[i]) we_cycles++;
    chk("mem_we_pulses", we_cycles, (ok && we) ? 1 : 0);
    if (!ok) chk("err_mem_a_kept", mem_a[i], a_before);
    e = sb.pop_front();
    chk("rsp_latency", lat, e.lat);
    chk("rsp_rdata", rsp_rdata[i], e.rdata);
    chk("rsp_err", rsp_err[i], e.err);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", rsp_valid[i], 1);
      chk("bp_rsp_rdata", rsp_rdata[i], e.rdata);
      chk("bp_req_ready", req_ready[i], 0);
      chk("bp_busy", busy[i], 1);
    end
    rsp_ready[i] = 1'b1;
    @(posedge clk); #1;
    exp_cnt[i] = (exp_cnt[i] + 1) & mask;
    chk("hs_rsp_valid", rsp_valid[i], 0);
    chk("hs_req_ready", req_ready[i], 1);
    chk("hs_access_cnt", get_cnt(i), exp_cnt[i]);
    // rsp_ready still high while idle: must not count again
    @(posedge clk); #1;
    rsp_ready[i] = 1'b0;
    chk("single_handshake", get_cnt(i), exp_cnt[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0; rsp_ready[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0; exp_cnt[i] = 0;
      for (int a = 0; a < 128; a++) ref_mem[i][a] = 32'h0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", req_ready[i], 1);
      chk("rst_rsp_valid", rsp_valid[i], 0);
      chk("rst_rsp_rdata", rsp_rdata[i], 0);
      chk("rst_rsp_err", rsp_err[i], 0);
      chk("rst_mem_we", mem_we[i], 0);
      chk("rst_mem_a", mem_a[i], 0);
      chk("rst_mem_wd", mem_wd[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_access_cnt", get_cnt(i), 0);
    end
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk); #1;

    access(0, 1'b1, 32'd5, 32'hDEADBEEF, 0);
    access(0, 1'b0, 32'd5, 32'h0, 0);
    access(0, 1'b0, 32'd128, 32'h0, 0);
    access(0, 1'b0, 32'hFFFFFFFF, 32'h0, 0);
    access(0, 1'b1, 32'd7, 32'h00000042, 0);
    access(0, 1'b0, 32'd7, 32'h0, 5);
    access(0, 1'b0, 32'd127, 32'h0, 0);

    // Reset during the WAIT state of a load.
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'd5; rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", busy[0], 1);
    chk("pre_rst_rsp_valid", rsp_valid[0], 0);
    rst[0] = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid[0], 0);
    chk("mid_rst_req_ready", req_ready[0], 1);
    chk("mid_rst_mem_we", mem_we[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_access_cnt", get_cnt(0), 0);
    @(posedge clk); #1;
    rst[0] = 1'b0; exp_cnt[0] = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("no_stale_rsp", rsp_valid[0], 0);
    end
    rsp_ready[0] = 1'b0;
    access(0, 1'b0, 32'd5, 32'h0, 0);

    // Longer memory latency and a 4-bit counter: 17 accesses wrap to 1.
    access(1, 1'b1, 32'd5, 32'hDEADBEEF, 0);
    access(1, 1'b0, 32'd5, 32'h0, 0);
    for (int k = 0; k < 15; k++) begin
      case (k % 3)
        0:       access(1, 1'b1, 32'(k + 10), $urandom, 0);
        1:       access(1, 1'b0, 32'(k + 9), 32'h0, (k == 4) ? 2 : 0);
        default: access(1, 1'b0, 32'(200 + k), 32'h0, 0);
      endcase
    end
    chk("cnt4_after_17", get_cnt(1), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/dmem_initiator.md
Name: dmem_initiator

Overview:
- Load/store access controller that acts as the requesting side of the data memory interface. The memory port is a synchronous single-port RAM: WE, address and write data are sampled on the clock edge, and RD is registered one or more edges later.
- Sits between the pipeline's memory stage and the data memory.
- Pipeline side: valid/ready request channel and valid/ready response channel.
- Handles one access at a time and sequences issue, latency wait and response.
- Range-checks addresses. Out-of-range accesses never reach the memory.

Parameters:
- WORD_SIZE, 32, width of data words and addresses.
- DATA_MEM_SIZE, 128, number of memory words; valid addresses are 0..DATA_MEM_SIZE-1.
- MEM_LAT, 1, number of edges after the issue edge until mem_rd holds read data; range 1..8.
- CNT_W, 16, width of the completed-access counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  pipeline request valid
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  WORD_SIZE  word address
- req_wdata  in  WORD_SIZE  store data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  pipeline accepts the response
- rsp_rdata  out  WORD_SIZE  load data; 0 for stores and errors
- rsp_err  out  1  address out of range
- mem_we  out  1  memory write enable
- mem_a  out  WORD_SIZE  memory address
- mem_wd  out  WORD_SIZE  memory write data
- mem_rd  in  WORD_SIZE  memory read data (registered in the memory)
- busy  out  1  high in every state other than IDLE
- access_cnt  out  CNT_W  number of completed response handshakes; wraps modulo 2^CNT_W

Behaviour:
- All outputs are registered.
- Reset values (applied asynchronously while rst=1):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_we=0, mem_a=0, mem_wd=0, access_cnt=0, busy=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, the request is accepted and req_ready drops.
  - In-range address (req_addr < DATA_MEM_SIZE):
    - mem_a <= req_addr, mem_wd <= req_wdata, mem_we <= req_we.
    - Next state is ISSUE.
  - Out-of-range address:
    - mem_we stays 0 and mem_a is unchanged.
    - rsp_err <= 1, rsp_rdata <= 0.
    - Next state is RESP.
- ISSUE (exactly one cycle):
  - The memory samples mem_a/mem_wd/mem_we at the edge that ends this cycle.
  - At that edge mem_we <= 0, so a store produces exactly one cycle of mem_we=1.
  - Store: rsp_rdata <= 0, rsp_err <= 0, next state is RESP.
  - Load: the latency counter is loaded with MEM_LAT-1, next state is WAIT.
- WAIT:
  - If the counter is nonzero, decrement it and stay in WAIT.
  - If the counter is 0, mem_rd is valid this cycle. At the edge: rsp_rdata <= mem_rd, rsp_err <= 0, next state is RESP.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable until the handshake.
  - On an edge with rsp_ready=1: rsp_valid <= 0, access_cnt increments, req_ready <= 1, next state is IDLE.
- Latency from the accept edge to the first rsp_valid=1 cycle:
  - Load: MEM_LAT+2 edges (3 for the default MEM_LAT=1).
  - Store: 2 edges.
  - Error: 1 edge.
- No new request is accepted before the previous response handshake completes. The minimum back-to-back spacing for a load with MEM_LAT=1 is 4 cycles.
- mem_a holds its last value outside ISSUE/WAIT. A read has no side effects on the memory, so this is harmless.
- rsp_ready=1 while rsp_valid=0 has no effect.
- req_valid=1 outside IDLE is ignored; the pipeline must hold the request until req_ready is sampled high.
- Read data for a load issued directly after a store to the same address is the stored value, because the store completes before the load is issued.
- Reset asserted mid-access:
  - Immediate return to IDLE and mem_we=0.
  - The pending response is discarded and access_cnt is cleared.
  - A store aborted in ISSUE may or may not have been written, depending on edge alignment with the reset assertion. The pipeline retries after reset.
- Address comparison is unsigned over the full WORD_SIZE bits.
- access_cnt wraps from 2^CNT_W-1 to 0.

Test Plan:
- Store addr=5, data=0xDEADBEEF, rsp_ready=1 → mem_we=1 for exactly 1 cycle with mem_a=5 and mem_wd=0xDEADBEEF; rsp_valid 2 edges after accept with rsp_rdata=0, rsp_err=0; access_cnt=1.
- Load addr=5 following that store, with the memory model preloaded → rsp_valid 3 edges after accept, rsp_rdata=0xDEADBEEF. Repeat with MEM_LAT=3 → rsp_valid after 5 edges, same data.
- Load addr=128 with DATA_MEM_SIZE=128 → no mem_we, mem_a unchanged, rsp_valid 1 edge after accept, rsp_err=1, rsp_rdata=0. Repeat with addr=0xFFFFFFFF → same result.
- Response backpressure: hold rsp_ready=0 for 5 cycles after a load of addr=7 (memory content 0x00000042) → rsp_valid and rsp_rdata=0x42 stay stable, req_ready=0 and busy=1 throughout; raising rsp_ready causes exactly one handshake and one access_cnt increment.
- Assert rst during WAIT of a load → rsp_valid=0, req_ready=1, mem_we=0 and access_cnt=0 immediately; no stale response after reset deasserts; the next load of addr=5 completes normally.
- CNT_W=4: complete 17 accesses → access_cnt=1.
